seg7_scan_ctrl: RTL and testbench

Parametrised, time-multiplexed seven-segment display controller for the board top level; drives AN/A2G/DP from a hex word written by the processor or IO logic. Generalises the fixed 8-digit scan to NUM_DIGITS digits, with a programmable refresh rate, per-digit enables, per-digit decimal points, anti-ghost blanking and tear-free double-buffered updates committed only at frame boundaries.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan controller.
package seg7_pkg;

  // Active-low segment vector, bit 6 = a ... bit 0 = g.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Hex nibble to active-low {a,b,c,d,e,f,g}; lowercase glyphs for b and d.
  function automatic seg7_t hex2seg(input logic [3:0] nib);
    seg7_t s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder used on the scan mux output.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment display controller.
// Scans NUM_DIGITS digits, REFRESH_DIV clocks per digit slot, with the first
// BLANK_CYCLES of every slot dark to suppress ghosting. Writes land in a
// pending buffer and are committed to the display buffer only when the scan
// wraps to digit 0, so a frame never shows a mix of old and new digits.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN -- when defined, zero
// digits above the most-significant nonzero enabled digit are suppressed
// (digit 0 is always shown).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   AN,
  output seg7_t                   A2G,
  output logic                    DP,
  output logic                    frame_start,
  output logic                    pend_valid
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           presc_q;
  logic [IW-1:0]           idx_q;

  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_en;

  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [NUM_DIGITS-1:0]   disp_en;

  logic                    slot_end;
  logic                    frame_wrap;
  logic                    commit;
  logic [PW-1:0]           presc_nxt;
  logic [IW-1:0]           idx_nxt;
  logic [4*NUM_DIGITS-1:0] disp_data_nxt;
  logic [NUM_DIGITS-1:0]   disp_dp_nxt;
  logic [NUM_DIGITS-1:0]   disp_en_nxt;
  logic [NUM_DIGITS-1:0]   eff_en_nxt;
  logic [3:0]              nib_p0;
  seg7_t                   seg_p0;
  logic                    lit_p0;
  logic [NUM_DIGITS-1:0]   an_p0;
  seg7_t                   a2g_p0;
  logic                    dp_p0;

  // Slot/frame sequencing. Outputs are computed from the next state so the
  // registered AN/A2G/DP line up with the slot that the counters enter.
  assign slot_end   = (presc_q == PW'(REFRESH_DIV - 1));
  assign frame_wrap = slot_end && (idx_q == IW'(NUM_DIGITS - 1));
  assign commit     = frame_wrap && pend_valid;
  assign presc_nxt  = slot_end ? '0 : presc_q + PW'(1);
  assign idx_nxt    = frame_wrap ? '0 : (slot_end ? idx_q + IW'(1) : idx_q);

  assign disp_data_nxt = commit ? pend_data : disp_data;
  assign disp_dp_nxt   = commit ? pend_dp   : disp_dp;
  assign disp_en_nxt   = commit ? pend_en   : disp_en;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask_q;
  logic [NUM_DIGITS-1:0] lz_mask_nxt;

  // Zero digits above the highest nonzero enabled digit; digit 0 is exempt.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(
    input logic [4*NUM_DIGITS-1:0] d,
    input logic [NUM_DIGITS-1:0]   en
  );
    logic [NUM_DIGITS-1:0] m;
    logic                  seen;
    m    = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (en[i] && (d[4*i +: 4] != 4'h0)) seen = 1'b1;
      if (!seen && (d[4*i +: 4] == 4'h0)) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign lz_mask_nxt = commit ? lz_mask(pend_data, pend_en) : lz_mask_q;
  assign eff_en_nxt  = disp_en_nxt & ~lz_mask_nxt;

  // Blank mask is captured together with the display buffer at commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lz_mask_q <= '0;
    else        lz_mask_q <= lz_mask_nxt;
  end
`else
  assign eff_en_nxt = disp_en_nxt;
`endif

  // ---- stage p0: select and decode the digit for the upcoming cycle ----
  assign nib_p0 = disp_data_nxt[4*idx_nxt +: 4];
  assign lit_p0 = eff_en_nxt[idx_nxt] && (presc_nxt >= PW'(BLANK_CYCLES));

  seg7_decode u_decode (
    .nibble (nib_p0),
    .seg    (seg_p0)
  );

  // Drive exactly one anode low, and only outside the blanking window.
  always_comb begin
    an_p0  = '1;
    a2g_p0 = SEG_BLANK;
    dp_p0  = 1'b1;
    if (lit_p0) begin
      an_p0[idx_nxt] = 1'b0;
      a2g_p0         = seg_p0;
      dp_p0          = ~disp_dp_nxt[idx_nxt];
    end
  end

  // Prescaler and digit index advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_nxt;
      idx_q   <= idx_nxt;
    end
  end

  // Pending buffer: last write wins; a load on the boundary cycle re-arms it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_data  <= data_in;
      pend_dp    <= dp_in;
      pend_en    <= digit_en;
      pend_valid <= 1'b1;
    end else if (commit) begin
      pend_valid <= 1'b0;
    end
  end

  // Display buffer updates only at a frame boundary with a pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_data <= '0;
      disp_dp   <= '0;
      disp_en   <= '0;
    end else begin
      disp_data <= disp_data_nxt;
      disp_dp   <= disp_dp_nxt;
      disp_en   <= disp_en_nxt;
    end
  end

  // ---- stage p1: registered pad outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      AN          <= '1;
      A2G         <= SEG_BLANK;
      DP          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      AN          <= an_p0;
      A2G         <= a2g_p0;
      DP          <= dp_p0;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits, 4 clocks per slot and a
// one-clock blank at the start of each slot (16-clock frame).
module tb_seg7_scan_ctrl;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   data_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    digit_en = '0;
  logic [3:0]    AN;
  logic [6:0]    A2G;
  logic          DP;
  logic          frame_start;
  logic          pend_valid;

  int n_pass = 0;
  int n_total = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .AN          (AN),
    .A2G         (A2G),
    .DP          (DP),
    .frame_start (frame_start),
    .pend_valid  (pend_valid)
  );

  always #5 clk = ~clk;

  // Reference segment table, active-low abcdefg.
  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  // Frame cycle c: slot c/4, prescaler c%4; cycle 0 of each slot is blank.
  function automatic logic is_lit(input logic [3:0] en, input int c);
    return en[c/4] && ((c % 4) >= 1);
  endfunction

  function automatic logic [3:0] exp_an(input logic [3:0] en, input int c);
    logic [3:0] a;
    a = 4'hF;
    if (is_lit(en, c)) a[c/4] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_a2g(input logic [15:0] d, input logic [3:0] en, input int c);
    if (is_lit(en, c)) return ref_seg(d[4*(c/4) +: 4]);
    return 7'h7F;
  endfunction

  function automatic logic exp_dp(input logic [3:0] dp, input logic [3:0] en, input int c);
    if (is_lit(en, c)) return ~dp[c/4];
    return 1'b1;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (frame_start === 1'b1) return;
    end
    n_total++;
    $display("FAIL wait_frame_start: no frame_start within 64 cycles");
  endtask

  task automatic test_reset();
    int k;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (AN !== 4'hF || A2G !== 7'h7F || DP !== 1'b1 || pend_valid !== 1'b0 || frame_start !== 1'b0)
      $display("FAIL reset_outputs: AN=%h A2G=%b DP=%b pv=%b fs=%b, want F 1111111 1 0 0",
               AN, A2G, DP, pend_valid, frame_start);
    else n_pass++;
    step(3);
    n_total++;
    if (AN !== 4'hF || A2G !== 7'h7F || pend_valid !== 1'b0)
      $display("FAIL reset_hold: AN=%h A2G=%b pv=%b", AN, A2G, pend_valid);
    else n_pass++;
    reset = 1'b1;
    wait_fs();
    step(1);
    n_total++;
    if (frame_start !== 1'b0) $display("FAIL fs_pulse_width: fs=%b want 0", frame_start);
    else n_pass++;
    k = 1;
    while (k < 32 && frame_start !== 1'b1) begin
      step(1);
      k++;
    end
    n_total++;
    if (k != 16) $display("FAIL fs_period: got %0d cycles, want 16", k);
    else n_pass++;
  endtask

  task automatic test_load_display();
    step(2);
    data_in = 16'h1234; digit_en = 4'hF; dp_in = 4'b0010; load = 1'b1;
    step(1);
    load = 1'b0;
    for (int c = 3; c < 16; c++) begin
      n_total++;
      if (pend_valid !== 1'b1) $display("FAIL pend_before_commit c=%0d: pv=%b want 1", c, pend_valid);
      else n_pass++;
      step(1);
    end
    n_total++;
    if (frame_start !== 1'b1 || pend_valid !== 1'b0)
      $display("FAIL commit_edge: fs=%b pv=%b want 1 0", frame_start, pend_valid);
    else n_pass++;
    for (int c = 0; c < 16; c++) begin
      n_total++;
      if (AN !== exp_an(4'hF, c) || A2G !== exp_a2g(16'h1234, 4'hF, c) || DP !== exp_dp(4'b0010, 4'hF, c))
        $display("FAIL scan_1234 c=%0d: AN=%h A2G=%b DP=%b want %h %b %b", c, AN, A2G, DP,
                 exp_an(4'hF, c), exp_a2g(16'h1234, 4'hF, c), exp_dp(4'b0010, 4'hF, c));
      else n_pass++;
      step(1);
    end
  endtask

  task automatic test_tearing();
    for (int c = 0; c < 16; c++) begin
      n_total++;
      if (AN !== exp_an(4'hF, c) || A2G !== exp_a2g(16'h1234, 4'hF, c) || DP !== exp_dp(4'b0010, 4'hF, c))
        $display("FAIL no_tear c=%0d: AN=%h A2G=%b DP=%b want %h %b %b", c, AN, A2G, DP,
                 exp_an(4'hF, c), exp_a2g(16'h1234, 4'hF, c), exp_dp(4'b0010, 4'hF, c));
      else n_pass++;
      if (c == 9) begin
        data_in = 16'hABCD; digit_en = 4'hF; dp_in = 4'b0000; load = 1'b1;
      end else load = 1'b0;
      step(1);
    end
    load = 1'b0;
    n_total++;
    if (frame_start !== 1'b1) $display("FAIL tear_frame_start: fs=%b want 1", frame_start);
    else n_pass++;
    for (int c = 0; c < 16; c++) begin
      n_total++;
      if (AN !== exp_an(4'hF, c) || A2G !== exp_a2g(16'hABCD, 4'hF, c) || DP !== exp_dp(4'b0000, 4'hF, c))
        $display("FAIL scan_abcd c=%0d: AN=%h A2G=%b DP=%b want %h %b %b", c, AN, A2G, DP,
                 exp_an(4'hF, c), exp_a2g(16'hABCD, 4'hF, c), exp_dp(4'b0000, 4'hF, c));
      else n_pass++;
      step(1);
    end
  endtask

  task automatic test_load_on_boundary();
    for (int c = 0; c < 16; c++) begin
      if (c == 5) begin
        data_in = 16'h5678; digit_en = 4'hF; dp_in = 4'b0000; load = 1'b1;
      end else if (c == 15) begin
        data_in = 16'h9ABC; digit_en = 4'hF; dp_in = 4'b1001; load = 1'b1;
      end else load = 1'b0;
      step(1);
    end
    load = 1'b0;
    for (int c = 0; c < 16; c++) begin
      n_total++;
      if (pend_valid !== 1'b1 || AN !== exp_an(4'hF, c) || A2G !== exp_a2g(16'h5678, 4'hF, c) ||
          DP !== exp_dp(4'b0000, 4'hF, c))
        $display("FAIL boundary_old c=%0d: pv=%b AN=%h A2G=%b DP=%b want 1 %h %b %b", c, pend_valid,
                 AN, A2G, DP, exp_an(4'hF, c), exp_a2g(16'h5678, 4'hF, c), exp_dp(4'b0000, 4'hF, c));
      else n_pass++;
      step(1);
    end
    n_total++;
    if (frame_start !== 1'b1 || pend_valid !== 1'b0)
      $display("FAIL boundary_commit: fs=%b pv=%b want 1 0", frame_start, pend_valid);
    else n_pass++;
    for (int c = 0; c < 16; c++) begin
      n_total++;
      if (AN !== exp_an(4'hF, c) || A2G !== exp_a2g(16'h9ABC, 4'hF, c) || DP !== exp_dp(4'b1001, 4'hF, c))
        $display("FAIL boundary_new c=%0d: AN=%h A2G=%b DP=%b want %h %b %b", c, AN, A2G, DP,
                 exp_an(4'hF, c), exp_a2g(16'h9ABC, 4'hF, c), exp_dp(4'b1001, 4'hF, c));
      else n_pass++;
      step(1);
    end
  endtask

  task automatic test_digit_en();
    data_in = 16'h1234; digit_en = 4'b0101; dp_in = 4'b1111; load = 1'b1;
    step(1);
    load = 1'b0;
    step(15);
    for (int c = 0; c < 48; c++) begin
      n_total++;
      if (AN[1] !== 1'b1 || AN[3] !== 1'b1 || AN !== exp_an(4'b0101, c % 16) ||
          A2G !== exp_a2g(16'h1234, 4'b0101, c % 16) || DP !== exp_dp(4'b1111, 4'b0101, c % 16))
        $display("FAIL digit_en c=%0d: AN=%h A2G=%b DP=%b want %h %b %b", c, AN, A2G, DP,
                 exp_an(4'b0101, c % 16), exp_a2g(16'h1234, 4'b0101, c % 16), exp_dp(4'b1111, 4'b0101, c % 16));
      else n_pass++;
      step(1);
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] en_a;
    logic [3:0] en_b;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    en_a = 4'b0011;
    en_b = 4'b0001;
`else
    en_a = 4'b1111;
    en_b = 4'b1111;
`endif
    data_in = 16'h0012; digit_en = 4'hF; dp_in = 4'b0000; load = 1'b1;
    step(1);
    load = 1'b0;
    step(15);
    for (int c = 0; c < 16; c++) begin
      n_total++;
      if (AN !== exp_an(en_a, c) || A2G !== exp_a2g(16'h0012, en_a, c))
        $display("FAIL lz_0012 c=%0d: AN=%h A2G=%b want %h %b", c, AN, A2G,
                 exp_an(en_a, c), exp_a2g(16'h0012, en_a, c));
      else n_pass++;
      step(1);
    end
    data_in = 16'h0000; load = 1'b1;
    step(1);
    load = 1'b0;
    step(15);
    for (int c = 0; c < 16; c++) begin
      n_total++;
      if (AN !== exp_an(en_b, c) || A2G !== exp_a2g(16'h0000, en_b, c))
        $display("FAIL lz_0000 c=%0d: AN=%h A2G=%b want %h %b", c, AN, A2G,
                 exp_an(en_b, c), exp_a2g(16'h0000, en_b, c));
      else n_pass++;
      step(1);
    end
  endtask

  task automatic test_reset_midframe();
    step(2);
    data_in = 16'h5555; digit_en = 4'hF; dp_in = 4'b0000; load = 1'b1;
    step(1);
    load = 1'b0;
    step(6);
    reset = 1'b0;
    #1;
    n_total++;
    if (AN !== 4'hF || A2G !== 7'h7F || DP !== 1'b1 || pend_valid !== 1'b0 || frame_start !== 1'b0)
      $display("FAIL reset_async: AN=%h A2G=%b DP=%b pv=%b fs=%b, want F 1111111 1 0 0",
               AN, A2G, DP, pend_valid, frame_start);
    else n_pass++;
    step(2);
    reset = 1'b1;
    for (int c = 0; c < 40; c++) begin
      n_total++;
      if (AN !== 4'hF || A2G !== 7'h7F || DP !== 1'b1 || pend_valid !== 1'b0)
        $display("FAIL post_reset_blank c=%0d: AN=%h A2G=%b DP=%b pv=%b", c, AN, A2G, DP, pend_valid);
      else n_pass++;
      step(1);
    end
  endtask

  initial begin
    test_reset();
    test_load_display();
    test_tearing();
    test_load_on_boundary();
    test_digit_en();
    test_leading_zero();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
